// File: rtl/mmio_pwm_responder.sv
// Memory-mapped peripheral responder: sized loads/stores (RV32I funct3) with a
// one-cycle ack, PWM duty/control registers driving four pins, and free-running
// microsecond and millisecond counters.
module mmio_pwm_responder #(
    parameter int unsigned CLK_HZ = 12_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wen,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ack,
    output logic        err,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned UsDiv = CLK_HZ / 1_000_000;
    localparam int unsigned MsDiv = CLK_HZ / 1000;
    localparam logic [31:0] UsLast = 32'(UsDiv - 1);
    localparam logic [31:0] MsLast = 32'(MsDiv - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] duty_q;
    logic [1:0]  ctrl_q;
    logic [31:0] micros_q, millis_q;
    logic [31:0] us_pre_q, ms_pre_q;
    logic [7:0]  pwm_cnt_q;

    // Only address[3:0] is decoded; the upper bits are latched but unused.
    logic unused_addr;
    assign unused_addr = ^addr_q[31:4];

    logic        is_byte, is_half, is_word, acc_err;
    logic [31:0] word_sel, load_data, wdata_rep, duty_wr, ctrl_wr;
    logic [3:0]  wmask;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Decode the latched access: error check, load lane extraction, store merge.
    always_comb begin
        is_byte = (funct3_q[1:0] == 2'b00);
        is_half = (funct3_q[1:0] == 2'b01);
        is_word = (funct3_q == 3'b010);

        acc_err = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11)
               || (wen_q && funct3_q[2])
               || (is_word && (addr_q[1:0] != 2'b00))
               || (is_half && addr_q[0])
               || (wen_q && ((addr_q[3:2] == 2'd1) || (addr_q[3:2] == 2'd2)));

        unique case (addr_q[3:2])
            2'd0:    word_sel = duty_q;
            2'd1:    word_sel = micros_q;
            2'd2:    word_sel = millis_q;
            default: word_sel = {30'b0, ctrl_q};
        endcase

        byte_val = 8'(word_sel >> {addr_q[1:0], 3'b000});
        half_val = 16'(word_sel >> {addr_q[1], 4'b0000});

        if (is_byte) begin
            load_data = funct3_q[2] ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
        end else if (is_half) begin
            load_data = funct3_q[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
        end else begin
            load_data = word_sel;
        end

        if (is_byte) begin
            wmask     = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            wmask     = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
        end else begin
            wmask     = 4'b1111;
            wdata_rep = wdata_q;
        end

        duty_wr = duty_q;
        ctrl_wr = {30'b0, ctrl_q};
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                duty_wr[i*8 +: 8] = wdata_rep[i*8 +: 8];
                ctrl_wr[i*8 +: 8] = wdata_rep[i*8 +: 8];
            end
        end
    end

    // Access FSM: sample in IDLE, perform in BUSY, acknowledge in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wen_q     <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            read_data <= 32'b0;
            duty_q    <= 32'b0;
            ctrl_q    <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack       <= 1'b0;
                    err       <= 1'b0;
                    read_data <= 32'b0;
                    if (req) begin
                        wen_q    <= wen;
                        funct3_q <= funct3;
                        addr_q   <= address;
                        wdata_q  <= write_data;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    ack       <= 1'b1;
                    err       <= acc_err;
                    read_data <= (acc_err || wen_q) ? 32'b0 : load_data;
                    if (wen_q && !acc_err) begin
                        if (addr_q[3:2] == 2'd0) duty_q <= duty_wr;
                        if (addr_q[3:2] == 2'd3) ctrl_q <= ctrl_wr[1:0];
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    ack       <= 1'b0;
                    err       <= 1'b0;
                    read_data <= 32'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Free-running time counters with independent prescalers; never paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_pre_q <= 32'b0;
            ms_pre_q <= 32'b0;
            micros_q <= 32'b0;
            millis_q <= 32'b0;
        end else begin
            if (us_pre_q == UsLast) begin
                us_pre_q <= 32'b0;
                micros_q <= micros_q + 32'd1;
            end else begin
                us_pre_q <= us_pre_q + 32'd1;
            end
            if (ms_pre_q == MsLast) begin
                ms_pre_q <= 32'b0;
                millis_q <= millis_q + 32'd1;
            end else begin
                ms_pre_q <= ms_pre_q + 32'd1;
            end
        end
    end

    // PWM counter and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 8'd0;
            led       <= 1'b0;
            red       <= 1'b0;
            green     <= 1'b0;
            blue      <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            led       <= (ctrl_q[0] & (pwm_cnt_q < duty_q[7:0]))   ^ ctrl_q[1];
            red       <= (ctrl_q[0] & (pwm_cnt_q < duty_q[15:8]))  ^ ctrl_q[1];
            green     <= (ctrl_q[0] & (pwm_cnt_q < duty_q[23:16])) ^ ctrl_q[1];
            blue      <= (ctrl_q[0] & (pwm_cnt_q < duty_q[31:24])) ^ ctrl_q[1];
        end
    end

endmodule
